// File: rtl/cook_time_setter.sv
// Cook-time setter: button levels -> minutes/seconds setting, committed as binary seconds on cfg exit.
// Optional both-button hold clear is enabled by defining SETTER_CLEAR_EN.
module cook_time_setter #(
    parameter int HOLD_CYCLES   = 2500000,
    parameter int REPEAT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_en,
    input  logic        mins_btn,
    input  logic        secs_btn,
    output logic [5:0]  min_val,
    output logic [5:0]  sec_val,
    output logic        editing,
    output logic [11:0] load_val,
    output logic        load_strobe
);
    // state   | meaning
    // IDLE    | waiting for cfg_en, buttons ignored
    // EDIT    | buttons adjust min_val/sec_val
    // COMMIT  | one cycle; load_val/load_strobe update on exit
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LOAD  = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
    state_t state, state_nxt;

    logic          commit, edit_act, suppress, clear_now;
    logic [1:0]    btn, hist, rise, arm, rep, inc;
    logic [CW-1:0] cnt [2];
    logic [11:0]   min_ext, total;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_en) state_nxt = EDIT;
            EDIT:    if (!cfg_en) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        editing  = (state == EDIT);
        commit   = (state == COMMIT);
        edit_act = (state == EDIT) && cfg_en;
    end

    assign btn  = {secs_btn, mins_btn};
    assign rise = btn & ~hist;

    always_comb begin
        for (int i = 0; i < 2; i++)
            rep[i] = arm[i] && btn[i] && (cnt[i] == '0);
    end

    assign inc = {2{edit_act}} & (rise | (rep & ~{2{suppress}}));

    // Per-button hold timers: load HOLD on press, reload REPEAT at each terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            arm  <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            hist <= btn;
            for (int i = 0; i < 2; i++) begin
                if (!edit_act || !btn[i]) begin
                    arm[i] <= 1'b0;
                    cnt[i] <= '0;
                end else if (rise[i]) begin
                    arm[i] <= 1'b1;
                    cnt[i] <= HOLD_LOAD;
                end else if (arm[i]) begin
                    cnt[i] <= (cnt[i] == '0) ? REP_LOAD : cnt[i] - CW'(1);
                end
            end
        end
    end

`ifdef SETTER_CLEAR_EN
    logic          both_held, both_arm;
    logic [CW-1:0] both_cnt;

    assign both_held = edit_act && (&btn);
    assign clear_now = both_held && both_arm && (rise == 2'b00) && (both_cnt == '0);

    // Both-button timer restarts from whichever press completes the pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            both_arm <= 1'b0;
            both_cnt <= '0;
            suppress <= 1'b0;
        end else begin
            if (!both_held) begin
                both_arm <= 1'b0;
                both_cnt <= '0;
            end else if ((|rise) && ((arm | rise) == 2'b11)) begin
                both_arm <= 1'b1;
                both_cnt <= HOLD_LOAD;
            end else if (both_arm) begin
                if (both_cnt == '0) both_arm <= 1'b0;
                else                both_cnt <= both_cnt - CW'(1);
            end
            if (!edit_act || (btn == 2'b00)) suppress <= 1'b0;
            else if (clear_now)              suppress <= 1'b1;
        end
    end
`else
    assign clear_now = 1'b0;
    assign suppress  = 1'b0;
`endif

    function automatic logic [5:0] wrap_inc(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    assign min_ext = {6'd0, min_val};
    assign total   = (min_ext << 6) - (min_ext << 2) + {6'd0, sec_val};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_val     <= '0;
            sec_val     <= '0;
            load_val    <= '0;
            load_strobe <= 1'b0;
        end else begin
            if (clear_now) begin
                min_val <= '0;
                sec_val <= '0;
            end else begin
                if (inc[0]) min_val <= wrap_inc(min_val);
                if (inc[1]) sec_val <= wrap_inc(sec_val);
            end
            load_strobe <= commit;
            if (commit) load_val <= total;
        end
    end

endmodule

// File: doc/cook_time_setter.md
Name: cook_time_setter

Overview:
- Producer side of the countdown timer's load interface: converts debounced minute/second button levels into the 12-bit binary seconds value the countdown timer loads.
- Active only while cook_time configuration is asserted. Commits the value with a one-cycle strobe when configuration ends.
- Sits between the debouncers and the countdown timer, clocked from the 5 MHz domain.

Parameters:
- HOLD_CYCLES, 2500000, cycles a button must stay high before auto-repeat starts (0.5 s at 5 MHz).
- REPEAT_CYCLES, 1000000, cycles between auto-repeat increments while held (0.2 s at 5 MHz).

Ports:
- clk  input  1  5 MHz system clock
- rst  input  1  asynchronous active-high reset
- cfg_en  input  1  configuration mode level (cook_time); edit while high
- mins_btn  input  1  debounced minutes button level
- secs_btn  input  1  debounced seconds button level
- min_val  output  6  current minutes setting, 0..59
- sec_val  output  6  current seconds setting, 0..59
- editing  output  1  high while state is EDIT
- load_val  output  12  committed value, min_val*60+sec_val, binary seconds
- load_strobe  output  1  one-cycle pulse when load_val is updated

Behaviour:
- Reset (async, rst=1):
  - min_val=0, sec_val=0, load_val=0, load_strobe=0, editing=0.
  - State=IDLE, hold/repeat counters=0, button history registers=0.
  - Reset mid-edit discards all edits. No strobe is issued.
- States: IDLE, EDIT, COMMIT. All transitions occur on rising edge of clk.
  - IDLE: cfg_en=1 -> EDIT. Buttons are ignored.
  - EDIT: editing=1. cfg_en=0 -> COMMIT. Button actions in that same cycle are ignored; the transition has priority.
  - COMMIT: lasts exactly one cycle, then -> IDLE. On the edge leaving COMMIT, load_val <= min_val*60+sec_val and load_strobe=1 for exactly that following cycle. Buttons are ignored.
- Latency: cfg_en sampled low at edge k -> COMMIT after edge k -> load_val/load_strobe valid after edge k+1.
- If cfg_en returns high during COMMIT, the commit still completes; the block returns to IDLE, then enters EDIT on the next edge.
- Edge detection:
  - History registers track mins_btn/secs_btn every cycle in all states.
  - A button already high when EDIT is entered produces no increment until it is released and pressed again.
- Increment (EDIT only):
  - Rising edge of mins_btn: min_val+1, with 59 wrapping to 0.
  - Rising edge of secs_btn: sec_val+1, with 59 wrapping to 0. No carry into minutes.
  - Both rising in the same cycle: both increment.
- Auto-repeat (per button, independent counters):
  - While the button is high in EDIT, its counter counts cycles.
  - At HOLD_CYCLES after the press edge: one extra increment, then one increment every REPEAT_CYCLES.
  - Release or leaving EDIT clears the counter.
- Arithmetic:
  - min_val*60 is computed as (min<<6)-(min<<2), 12-bit.
  - Maximum load_val = 3599 (59:59); it never exceeds 12 bits.
- min_val/sec_val persist across IDLE/EDIT cycles; they are cleared only by rst.
- load_val holds its value between commits.

Optional Feature:
- Macro: SETTER_CLEAR_EN.
- Defined:
  - In EDIT, both buttons held simultaneously for HOLD_CYCLES (measured from the later press) sets min_val=0 and sec_val=0 on that cycle.
  - All auto-repeat is suppressed until both buttons are released.
  - The press-edge increments that occurred before the clear are overwritten.
- Undefined: no clear function. Simultaneous holds auto-repeat both fields independently.

Test Plan (HOLD_CYCLES=8, REPEAT_CYCLES=4):
- Reset, cfg_en=1, pulse mins_btn 3x and secs_btn 2x (2 cycles high, 3 low each), cfg_en=0 -> min_val=3, sec_val=2, load_strobe high exactly one cycle 2 edges after cfg_en low, load_val=182.
- In EDIT, sec_val=58, pulse secs_btn twice -> sec_val=59 then 0; min_val unchanged. Then commit -> load_val=min*60.
- Hold mins_btn 20 cycles in EDIT starting min_val=0 -> increments at press edge, +8, +12, +16, +20 cycles; min_val=5.
- mins_btn high before cfg_en rises, kept high 3 cycles into EDIT, then released -> no increment. cfg_en drop coinciding with a secs_btn rising edge -> sec_val unchanged.
- Assert rst mid-EDIT with min_val=7 -> all outputs 0 immediately (asynchronous). No load_strobe after release. Subsequent cfg_en 1->0 commits load_val=0.
- With SETTER_CLEAR_EN defined, min_val=4 and sec_val=9, hold both buttons 10 cycles -> after both press edges (min=5, sec=10), at cycle 8 both become 0 and stay 0 through cycle 10. Without the macro -> repeat increments occur instead.
